rf_wb_scheduler: RTL
====================

// Module: rf_wb_scheduler
// PURPOSE
//   Shares the single register-file write port between the in-order ALU writeback and a long-latency unit (LSU/MULDIV).
//   Tracks destination registers of outstanding long-latency ops in a scoreboard.
//   Flags decode-stage RAW/WAW hazards against pending writes.
//   Sits between the WB stage / long-latency unit and the register file. Its registered write outputs drive WEN/RD_SEL/WB_DATA.
// PARAMETERS
//   ADDR_WIDTH      5   register index width (32 architectural regs, x0 hardwired zero)
//   DATA_WIDTH      32  writeback data width
//   MAX_OUTSTANDING 4   max in-flight long-latency ops; counter width = $clog2(MAX_OUTSTANDING+1)
//   STARVE_LIMIT    3   consecutive cycles LU may lose arbitration before forcing a pipeline stall
// PORTS
//   CLK          in  1   clock, all state on rising edge
//   RESET_N      in  1   synchronous reset, active low
//   ISSUE_VALID  in  1   decode dispatches a long-latency op this cycle
//   ISSUE_RD     in  AW  destination of dispatched op
//   ISSUE_READY  out 1   scheduler accepts the issue (comb)
//   DEC_RS1/RS2  in  AW  decode-stage source registers
//   DEC_RD       in  AW  decode-stage destination register
//   HAZARD       out 1   decode must stall: pending write to RS1/RS2/RD (comb)
//   ALU_WEN      in  1   ALU writeback request (no backpressure except PIPE_STALL)
//   ALU_RD       in  AW  ALU destination
//   ALU_DATA     in  DW  ALU result
//   LU_VALID     in  1   long-latency result valid
//   LU_RD        in  AW  long-latency destination
//   LU_DATA      in  DW  long-latency result
//   LU_READY     out 1   LU result accepted this cycle (comb)
//   PIPE_STALL   out 1   freeze pipeline; ALU holds its request (comb)
//   RF_WEN       out 1   to register file WEN (registered)
//   RF_RD        out AW  to register file RD_SEL (registered)
//   RF_DATA      out DW  to register file WB_DATA (registered)
//   BUSY_VEC     out 32  scoreboard snapshot, bit0 always 0 (registered)
// BEHAVIOUR
//   Reset (RESET_N=0 at edge): RF_WEN=0, RF_RD=0, RF_DATA=0, BUSY_VEC=0, outstanding count=0, starve count=0. Reset mid-op discards all in-flight state.
//   Arbitration (per cycle):
//     starve = (starve_cnt >= STARVE_LIMIT).
//     LU_READY = LU_VALID & (!ALU_WEN | starve).
//     PIPE_STALL = ALU_WEN & LU_VALID & starve.
//     ALU granted iff ALU_WEN & !PIPE_STALL.
//   starve_cnt: +1 when LU_VALID & !LU_READY; cleared on LU handshake or !LU_VALID; saturates.
//   Write port: granted source registered into RF_* next edge, so latency is 1 cycle.
//     RF_WEN = grant & (rd != 0); rd=0 writes are consumed but never reach the register file.
//   Scoreboard:
//     ISSUE_READY = (count < MAX_OUTSTANDING) & !busy[ISSUE_RD], using current-cycle busy.
//     Issue handshake with ISSUE_RD!=0 sets busy[ISSUE_RD]. count+1 on every issue, including rd=0.
//     LU handshake clears busy[LU_RD] and does count-1.
//     Issue and retire in the same cycle: count unchanged. Issue to the retiring rd is blocked that cycle (busy still set).
//   HAZARD = busy[DEC_RS1] | busy[DEC_RS2] | busy[DEC_RD]; index 0 never hazards.
//   Illegal (SVA assertions): LU handshake with count==0; ALU grant with busy[ALU_RD]; LU_RD not busy (rd!=0).
//   No same-cycle bypass inside this block; the register file's write-through covers RF_* -> read.
// STRUCTURE
//   rf_sched_pkg:
//     constants REG_COUNT=32 and ZERO_REG=0.
//     typedef wb_src_e {SRC_NONE, SRC_ALU, SRC_LU}.
//   Sub-module rf_scoreboard: busy vector, outstanding counter, ISSUE_READY/HAZARD logic.
//   Top level holds arbitration, starve counter, and output registers.
// TESTING
//   Reset: RESET_N=0 for 2 cycles with ALU_WEN=1 -> RF_WEN=0, BUSY_VEC=0, ISSUE_READY=1 after release.
//   Issue rd=5; decode RS1=5 -> HAZARD=1. LU_VALID rd=5 data=0xCAFE0001 -> LU_READY=1; next cycle RF_WEN=1, RF_RD=5, RF_DATA=0xCAFE0001, HAZARD=0.
//   Conflict: ALU_WEN=1 every cycle + LU_VALID, STARVE_LIMIT=3 -> ALU granted 3 cycles, then PIPE_STALL=1 and LU granted in 4th cycle; ALU granted the cycle after.
//   Full: 4 issues rd=1..4 -> ISSUE_READY=0 on 5th. Retire rd=2 while issuing rd=2 -> issue blocked; count drops to 3; issue rd=6 accepted next cycle.
//   Zero reg: ALU_WEN rd=0 and issue rd=0 -> RF_WEN stays 0; BUSY_VEC[0]=0; count increments; LU rd=0 retire decrements it.
//   Reset mid-operation: 3 outstanding, assert RESET_N=0 -> count=0, BUSY_VEC=0, HAZARD=0 next cycle.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package rf_sched_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LU
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard for outstanding long-latency ops: issue admission,
// retire clearing and decode hazard detection.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  retire_i,
  input  logic [ADDR_WIDTH-1:0] retire_rd_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic [ADDR_WIDTH-1:0] dec_rd_i,
  output logic                  hazard_o,
  output logic [REG_COUNT-1:0]  busy_o
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 issue_fire;

  // Admission uses the current busy state, so an rd retiring this cycle stays blocked.
  always_comb begin
    issue_ready_o = (count_q < CNT_WIDTH'(MAX_OUTSTANDING)) & ~busy_q[issue_rd_i];
    issue_fire    = issue_valid_i & issue_ready_o;
  end

  always_comb begin
    busy_d = busy_q;
    if (retire_i && (retire_rd_i != ADDR_WIDTH'(ZERO_REG))) begin
      busy_d[retire_rd_i] = 1'b0;
    end
    if (issue_fire && (issue_rd_i != ADDR_WIDTH'(ZERO_REG))) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;

    count_d = count_q;
    unique case ({issue_fire, retire_i})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Bit 0 is never set, so x0 sources never hazard.
  always_comb begin
    hazard_o = busy_q[dec_rs1_i] | busy_q[dec_rs2_i] | busy_q[dec_rd_i];
    busy_o   = busy_q;
  end

  a_retire_with_none_outstanding: assert property (
    @(posedge CLK) disable iff (!RESET_N) retire_i |-> (count_q != '0)
  );

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU writeback and the
// long-latency unit, with starvation-triggered pipeline stall and registered outputs.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
  output logic                  ISSUE_READY,
  input  logic [ADDR_WIDTH-1:0] DEC_RS1,
  input  logic [ADDR_WIDTH-1:0] DEC_RS2,
  input  logic [ADDR_WIDTH-1:0] DEC_RD,
  output logic                  HAZARD,
  input  logic                  ALU_WEN,
  input  logic [ADDR_WIDTH-1:0] ALU_RD,
  input  logic [DATA_WIDTH-1:0] ALU_DATA,
  input  logic                  LU_VALID,
  input  logic [ADDR_WIDTH-1:0] LU_RD,
  input  logic [DATA_WIDTH-1:0] LU_DATA,
  output logic                  LU_READY,
  output logic                  PIPE_STALL,
  output logic                  RF_WEN,
  output logic [ADDR_WIDTH-1:0] RF_RD,
  output logic [DATA_WIDTH-1:0] RF_DATA,
  output logic [REG_COUNT-1:0]  BUSY_VEC
);

  localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                    starve;
  logic                    alu_grant;
  wb_src_e                 wb_src;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

  // ALU wins by default; once the LU has lost STARVE_LIMIT times the pipe is frozen for it.
  always_comb begin
    starve     = (starve_cnt_q >= STARVE_WIDTH'(STARVE_LIMIT));
    LU_READY   = LU_VALID & (~ALU_WEN | starve);
    PIPE_STALL = ALU_WEN & LU_VALID & starve;
    alu_grant  = ALU_WEN & ~PIPE_STALL;

    wb_src = SRC_NONE;
    if (LU_READY) begin
      wb_src = SRC_LU;
    end else if (alu_grant) begin
      wb_src = SRC_ALU;
    end

    starve_cnt_d = '0;
    if (LU_VALID && !LU_READY) begin
      starve_cnt_d = starve ? starve_cnt_q : starve_cnt_q + STARVE_WIDTH'(1);
    end
  end

  // x0 writes are consumed by the grant but never assert the register-file enable.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    case (wb_src)
      SRC_ALU: begin
        rf_wen_d  = (ALU_RD != ADDR_WIDTH'(ZERO_REG));
        rf_rd_d   = ALU_RD;
        rf_data_d = ALU_DATA;
      end
      SRC_LU: begin
        rf_wen_d  = (LU_RD != ADDR_WIDTH'(ZERO_REG));
        rf_rd_d   = LU_RD;
        rf_data_d = LU_DATA;
      end
      default: rf_wen_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      starve_cnt_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_wen_q     <= rf_wen_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
    end
  end

  always_comb begin
    RF_WEN  = rf_wen_q;
    RF_RD   = rf_rd_q;
    RF_DATA = rf_data_q;
  end

  rf_scoreboard #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_sb (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .issue_valid_i (ISSUE_VALID),
    .issue_rd_i    (ISSUE_RD),
    .issue_ready_o (ISSUE_READY),
    .retire_i      (LU_READY),
    .retire_rd_i   (LU_RD),
    .dec_rs1_i     (DEC_RS1),
    .dec_rs2_i     (DEC_RS2),
    .dec_rd_i      (DEC_RD),
    .hazard_o      (HAZARD),
    .busy_o        (BUSY_VEC)
  );

  a_alu_write_to_busy_reg: assert property (
    @(posedge CLK) disable iff (!RESET_N)
    (alu_grant && (ALU_RD != ADDR_WIDTH'(ZERO_REG))) |-> !BUSY_VEC[ALU_RD]
  );

  a_lu_retire_not_busy: assert property (
    @(posedge CLK) disable iff (!RESET_N)
    (LU_READY && (LU_RD != ADDR_WIDTH'(ZERO_REG))) |-> BUSY_VEC[LU_RD]
  );

endmodule
